fifo_ofm_mc: RTL and testbench

- Parametrised successor to the single-lane OFM FIFO.
- Buffers NUM_CH output-feature-map lanes written and read as one packed word, so a full PE column result moves in a single beat between the conv array and the OFM writeback path.
- Adds over the single-lane version:
  - a correct-width occupancy count;
  - programmable almost-full and almost-empty flags;
  - a read-valid strobe;
  - write-while-full when a read occurs in the same cycle;
  - sticky overflow and underflow error flags;
  - one unified flush.
- Depth need not be a power of two.

---
 rtl/fifo_ofm_mc.sv | 107 ++++++++++
 tb/tb_fifo_ofm_mc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ofm_mc.sv
// Multi-lane OFM FIFO: NUM_CH lanes move as one packed word per beat.
// Provides occupancy, programmable almost-full/empty flags, sticky errors and flush.
module fifo_ofm_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 4608,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    input  logic                         rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [CNT_W-1:0]             count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int WORD_W = NUM_CH * DATA_WIDTH;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              wr_acc;
    logic              rd_acc;

    // Explicit wrap so a non-power-of-two depth never walks off the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_en);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + CNT_W'(1);
        else if (!wr_acc && rd_acc)
            count_nxt = count - CNT_W'(1);
    end

    // NOTE: storage has no reset; empty gates every read so stale words never reach rd_data.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count    <= count_nxt;
            rd_valid <= rd_acc;
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            // Reads the old head even when a write lands in the same cycle.
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= ptr_inc(rd_ptr);
            end
            if (wr_en && !wr_acc)
                overflow <= 1'b1;
            if (rd_en && !rd_acc)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ofm_mc.sv
// Directed bench for fifo_ofm_mc at DEPTH=5: fill, drain, wrap, full/empty R+W, flush, async reset.
module tb_fifo_ofm_mc;

    localparam int DW    = 16;
    localparam int NCH   = 4;
    localparam int DEPTH = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              wr_en;
    logic [NCH*DW-1:0] wr_data;
    logic              rd_en;
    logic [NCH*DW-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    int errors = 0;
    int checks = 0;

    fifo_ofm_mc #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NCH),
        .DEPTH     (DEPTH),
        .AF_THRESH (4),
        .AE_THRESH (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane k of a word with base b holds b + k.
    function automatic logic [NCH*DW-1:0] word(input logic [15:0] base);
        logic [NCH*DW-1:0] w;
        for (int k = 0; k < NCH; k++)
            w[k*DW +: DW] = base + 16'(k);
        return w;
    endfunction

    // Drive one cycle's inputs, clock once, then sample 1 time unit after the edge.
    task automatic cycle(input logic w, input logic [NCH*DW-1:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr     = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic check_flags(input string tag, input int cnt);
        check({tag, ".count"},        64'(count),        64'(cnt));
        check({tag, ".empty"},        64'(empty),        64'(cnt == 0));
        check({tag, ".full"},         64'(full),         64'(cnt == 5));
        check({tag, ".almost_full"},  64'(almost_full),  64'(cnt >= 4));
        check({tag, ".almost_empty"}, 64'(almost_empty), 64'(cnt <= 1));
    endtask

    task automatic check_reset_state(input string tag);
        check_flags(tag, 0);
        check({tag, ".rd_data"},   rd_data,          64'h0);
        check({tag, ".rd_valid"},  64'(rd_valid),    64'h0);
        check({tag, ".overflow"},  64'(overflow),    64'h0);
        check({tag, ".underflow"}, 64'(underflow),   64'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        #12;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill W0..W4, then one refused write.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, word(16'(16'h0100 * i)), 1'b0, 1'b0);
            check_flags($sformatf("fill%0d", i), i + 1);
            check("fill.overflow", 64'(overflow), 64'h0);
        end
        cycle(1'b1, word(16'hEE00), 1'b0, 1'b0);
        check_flags("fill_over", 5);
        check("fill_over.overflow", 64'(overflow), 64'h1);

        // Drain in order, then one refused read.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            check($sformatf("drain%0d.rd_valid", i), 64'(rd_valid), 64'h1);
            check($sformatf("drain%0d.rd_data", i),  rd_data, word(16'(16'h0100 * i)));
            check_flags($sformatf("drain%0d", i), 4 - i);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("drain_idle.rd_valid", 64'(rd_valid), 64'h0);
        check("drain_idle.rd_data_hold", rd_data, word(16'h0400));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("drain_under.underflow", 64'(underflow), 64'h1);
        check("drain_under.rd_valid",  64'(rd_valid),  64'h0);
        check("drain_under.overflow",  64'(overflow),  64'h1);

        cycle(1'b0, '0, 1'b0, 1'b1);
        check_reset_state("clr1");

        // Twelve write/read pairs wrap both pointers twice.
        for (int j = 0; j < 12; j++) begin
            cycle(1'b1, word(16'(16'hA000 + 16'h0010 * j)), 1'b0, 1'b0);
            check_flags($sformatf("wrap_w%0d", j), 1);
            cycle(1'b0, '0, 1'b1, 1'b0);
            check_flags($sformatf("wrap_r%0d", j), 0);
            check($sformatf("wrap_r%0d.rd_data", j), rd_data, word(16'(16'hA000 + 16'h0010 * j)));
            check($sformatf("wrap_r%0d.rd_valid", j), 64'(rd_valid), 64'h1);
        end

        // Full plus simultaneous read and write.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, word(16'(16'hB000 + 16'h0100 * i)), 1'b0, 1'b0);
        check_flags("full_pre", 5);
        cycle(1'b1, word(16'hB500), 1'b1, 1'b0);
        check_flags("full_rw", 5);
        check("full_rw.rd_data",  rd_data, word(16'hB000));
        check("full_rw.rd_valid", 64'(rd_valid), 64'h1);
        check("full_rw.overflow", 64'(overflow), 64'h0);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            check($sformatf("full_drain%0d.rd_data", i), rd_data, word(16'(16'hB000 + 16'h0100 * i)));
        end
        check_flags("full_drained", 0);
        check("full_drained.underflow", 64'(underflow), 64'h0);

        // Empty plus simultaneous read and write: write accepted, read refused.
        cycle(1'b1, word(16'hC000), 1'b1, 1'b0);
        check_flags("empty_rw", 1);
        check("empty_rw.rd_valid",  64'(rd_valid),  64'h0);
        check("empty_rw.underflow", 64'(underflow), 64'h1);
        check("empty_rw.rd_data",   rd_data, word(16'hB500));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("empty_rw_rd.rd_data", rd_data, word(16'hC000));
        check_flags("empty_rw_rd", 0);

        // Flush at count 3 with a concurrent write that must be dropped.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, word(16'(16'hD000 + 16'h0100 * i)), 1'b0, 1'b0);
        check_flags("flush_pre", 3);
        cycle(1'b1, word(16'hDD00), 1'b0, 1'b1);
        check_reset_state("flush");
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_flags("flush_idle", 0);
        cycle(1'b1, word(16'hE100), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("flush_after.rd_data", rd_data, word(16'hE100));
        check_flags("flush_after", 0);

        // Asynchronous reset mid-burst, between clock edges.
        cycle(1'b1, word(16'hF000), 1'b0, 1'b0);
        cycle(1'b1, word(16'hF100), 1'b0, 1'b0);
        cycle(1'b1, word(16'hF200), 1'b1, 1'b0);
        check("burst.rd_data", rd_data, word(16'hF000));
        check_flags("burst", 2);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = word(16'hF300);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("async_rst_held");
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("post_rst.underflow", 64'(underflow), 64'h1);
        check_flags("post_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
